// File: rtl/blockram_system_v2_nios2f_cpu_debug_avmm_bridge.sv
// rtl/blockram_system_v2_nios2f_cpu_debug_avmm_bridge.sv - debug-slave to Avalon-MM single-word master bridge
//
// Purpose: turns the sysclk-stage jdo word and take_*_ocimem strobes into single-word
// Avalon-MM reads/writes, returning data and status on MonDReg/monitor_ready/monitor_error.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   jdo[37:0]                            debug data (address, data, control bits 34/35)
//   take_action_ocimem_a                 load address; jdo[34] also starts a read; jdo[35] clears error
//   take_no_action_ocimem_a              read at current address
//   take_action_ocimem_b                 write jdo[31:0] at current address
//   MonDReg, monitor_ready, monitor_error  status back to the debug slave
//   avm_*                                Avalon-MM master (pipelined reads)
module blockram_system_v2_nios2f_cpu_debug_avmm_bridge #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int AW    = ADDR_W - 2;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DATA = 2'd2,
        WR_REQ  = 2'd3
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       mon_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic              error_q;
    logic              read_q;
    logic              write_q;

    logic [AW-1:0]     addr_inc_d;
    logic [CNT_W-1:0]  cnt_inc_d;
    logic              timeout_hit_d;
    logic              any_strobe_d;
    logic              access_done_d;
    logic              unused_jdo;

    // Bits of jdo with no meaning for this bridge.
    assign unused_jdo = ^{jdo[37:36], jdo[33:32]};

    always_comb begin
        addr_inc_d    = addr_q + AW'(1);
        cnt_inc_d     = cnt_q + CNT_W'(1);
        timeout_hit_d = (cnt_inc_d == CNT_W'(TIMEOUT_CYC));
        any_strobe_d  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        // A completion on the same edge as the timeout wins over the abort.
        access_done_d = ((state_q == RD_REQ) && read_q && !avm_waitrequest && avm_readdatavalid) ||
                        ((state_q == RD_DATA) && avm_readdatavalid) ||
                        ((state_q == WR_REQ) && write_q && !avm_waitrequest);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            mon_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // ocimem_b > ocimem_a > no_action_ocimem_a
                    if (take_action_ocimem_b) begin
                        mon_q   <= jdo[31:0];
                        wdata_q <= jdo[31:0];
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= WR_REQ;
                    end else if (take_action_ocimem_a) begin
                        addr_q <= jdo[ADDR_W-1:2];
                        if (jdo[35]) begin
                            error_q <= 1'b0;
                        end
                        if (jdo[34]) begin
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= RD_REQ;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    cnt_q <= cnt_inc_d;
                    // Request goes out one cycle after the state is entered.
                    if (!read_q) begin
                        read_q <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        read_q <= 1'b0;
                        if (avm_readdatavalid) begin
                            mon_q   <= avm_readdata;
                            addr_q  <= addr_inc_d;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    cnt_q <= cnt_inc_d;
                    if (avm_readdatavalid) begin
                        mon_q   <= avm_readdata;
                        addr_q  <= addr_inc_d;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WR_REQ: begin
                    cnt_q <= cnt_inc_d;
                    if (!write_q) begin
                        write_q <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        write_q <= 1'b0;
                        addr_q  <= addr_inc_d;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Commands arriving mid-access are dropped but flagged.
            if ((state_q != IDLE) && any_strobe_d) begin
                error_q <= 1'b1;
            end

            // Abort a stuck access; address stays where the failed access pointed.
            if ((state_q != IDLE) && timeout_hit_d && !access_done_d) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
                mon_q   <= 32'hDEADDEAD;
                error_q <= 1'b1;
                ready_q <= 1'b1;
                state_q <= IDLE;
            end
        end
    end

    assign MonDReg        = mon_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;
    assign avm_address    = {addr_q, 2'b00};
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_blockram_system_v2_nios2f_cpu_debug_avmm_bridge.sv
// tb/tb_blockram_system_v2_nios2f_cpu_debug_avmm_bridge.sv - self-checking bench for the debug AVMM bridge
module tb_blockram_system_v2_nios2f_cpu_debug_avmm_bridge;

    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta, tna, tb;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;

    blockram_system_v2_nios2f_cpu_debug_avmm_bridge #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tna), .take_action_ocimem_b(tb),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // slave knobs and logs
    int  cfg_wait = 0, cfg_dly = 0;
    bit  cfg_zl = 0, cfg_stall = 0, spurious_rdv = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    logic [3:0]  wr_be_q[$];
    logic [31:0] slv_mem[int];
    logic [31:0] ref_mem[int];

    // reference model state
    logic [29:0] m_addr;
    logic [31:0] m_mon;
    logic        m_err;

    function automatic logic [31:0] dflt(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return dflt(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [29:0] a);
        if (slv_mem.exists(int'(a))) return slv_mem[int'(a)];
        return dflt(a);
    endfunction

    // Avalon slave: decides waitrequest/readdatavalid on the falling edge
    bit          in_req = 0, pend = 0;
    int          wait_left = 0, dly_left = 0;
    logic [31:0] rd_val = '0;
    initial begin
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (!reset_n) begin
                in_req = 0;
                pend = 0;
                avm_waitrequest = 1'b1;
            end else begin
                if (pend) begin
                    if (dly_left == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = rd_val;
                        pend = 0;
                    end else begin
                        dly_left--;
                    end
                end
                if (spurious_rdv) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = 32'hBAD0BAD0;
                end
                if (avm_read || avm_write) begin
                    if (!in_req) begin
                        in_req = 1;
                        wait_left = cfg_wait;
                    end
                    if (cfg_stall || wait_left > 0) begin
                        avm_waitrequest = 1'b1;
                        if (wait_left > 0) wait_left--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        in_req = 0;
                        if (avm_write) begin
                            wr_addr_q.push_back(avm_address);
                            wr_data_q.push_back(avm_writedata);
                            wr_be_q.push_back(avm_byteenable);
                            slv_mem[int'(avm_address[31:2])] = avm_writedata;
                        end else begin
                            rd_addr_q.push_back(avm_address);
                            rd_val = slv_rd(avm_address[31:2]);
                            if (cfg_zl) begin
                                avm_readdatavalid = 1'b1;
                                avm_readdata = rd_val;
                            end else begin
                                pend = 1;
                                dly_left = cfg_dly;
                            end
                        end
                    end
                end else begin
                    in_req = 0;
                    avm_waitrequest = 1'b1;
                end
            end
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_addr = '0;
        m_mon  = '0;
        m_err  = 1'b0;
    endtask

    // kind: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b
    task automatic run_cmd(input int kind, input logic [31:0] val, input bit b34, input bit b35, input string tag);
        bit rd, wr;
        int exp_lat, n;
        logic [31:0] exp_baddr, got;
        rd = (kind == 1) || (kind == 0 && b34);
        wr = (kind == 2);
        if (kind == 0) begin
            m_addr = val[31:2];
            if (b35) m_err = 1'b0;
        end
        exp_baddr = {m_addr, 2'b00};
        exp_lat = 0;
        if (wr) begin
            ref_mem[int'(m_addr)] = val;
            m_mon = val;
            m_addr = m_addr + 30'd1;
            exp_lat = 2 + cfg_wait;
        end else if (rd) begin
            m_mon = ref_rd(m_addr);
            m_addr = m_addr + 30'd1;
            exp_lat = cfg_zl ? 2 + cfg_wait : 3 + cfg_wait + cfg_dly;
        end
        jdo = {2'b00, b35, b34, 2'b00, val};
        ta = (kind == 0); tna = (kind == 1); tb = (kind == 2);
        @(negedge clk);
        ta = 0; tna = 0; tb = 0;
        n = 0;
        while (monitor_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n !== exp_lat) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", tag, n, exp_lat); end
        n_vec++;
        if (MonDReg !== m_mon) begin n_err++; $display("FAIL %s MonDReg: got %h expected %h", tag, MonDReg, m_mon); end
        n_vec++;
        if (avm_address !== {m_addr, 2'b00}) begin n_err++; $display("FAIL %s next_addr: got %h expected %h", tag, avm_address, {m_addr, 2'b00}); end
        n_vec++;
        if (monitor_error !== m_err) begin n_err++; $display("FAIL %s error: got %b expected %b", tag, monitor_error, m_err); end
        n_vec++;
        if ({avm_read, avm_write} !== 2'b00) begin n_err++; $display("FAIL %s bus_idle: got rd=%b wr=%b expected 0 0", tag, avm_read, avm_write); end
        n_vec++;
        if (wr_addr_q.size() !== (wr ? 1 : 0) || rd_addr_q.size() !== (rd ? 1 : 0)) begin
            n_err++;
            $display("FAIL %s bus_count: got wr=%0d rd=%0d expected wr=%0d rd=%0d", tag, wr_addr_q.size(), rd_addr_q.size(), wr, rd);
            wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); rd_addr_q.delete();
        end else if (wr) begin
            got = wr_addr_q.pop_front();
            n_vec++;
            if (got !== exp_baddr) begin n_err++; $display("FAIL %s wr_addr: got %h expected %h", tag, got, exp_baddr); end
            got = wr_data_q.pop_front();
            n_vec++;
            if (got !== val) begin n_err++; $display("FAIL %s wr_data: got %h expected %h", tag, got, val); end
            got = {28'd0, wr_be_q.pop_front()};
            n_vec++;
            if (got !== 32'hF) begin n_err++; $display("FAIL %s byteenable: got %h expected f", tag, got); end
        end else if (rd) begin
            got = rd_addr_q.pop_front();
            n_vec++;
            if (got !== exp_baddr) begin n_err++; $display("FAIL %s rd_addr: got %h expected %h", tag, got, exp_baddr); end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({monitor_ready, monitor_error, avm_read, avm_write} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags: got rdy=%b err=%b rd=%b wr=%b expected 1 0 0 0", monitor_ready, monitor_error, avm_read, avm_write);
        end
        n_vec++;
        if (MonDReg !== 32'h0 || avm_address !== 32'h0) begin
            n_err++; $display("FAIL reset_regs: got mon=%h addr=%h expected 0 0", MonDReg, avm_address);
        end
    endtask

    task automatic test_read_basic();
        slv_mem[32'h100] = 32'h12345678;
        ref_mem[32'h100] = 32'h12345678;
        cfg_wait = 1; cfg_dly = 0; cfg_zl = 0;
        run_cmd(0, 32'h400, 1, 0, "read_basic");
        n_vec++;
        if (MonDReg !== 32'h12345678 || avm_address !== 32'h404) begin
            n_err++; $display("FAIL read_basic_const: got mon=%h addr=%h expected 12345678 404", MonDReg, avm_address);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3] = '{32'hA, 32'hB, 32'hC};
        cfg_wait = 0;
        run_cmd(0, 32'h400, 0, 0, "b2b_load");
        for (int i = 0; i < 3; i++) run_cmd(2, vals[i], 0, 0, "b2b_write");
        n_vec++;
        if (MonDReg !== 32'hC || avm_address !== 32'h40C) begin
            n_err++; $display("FAIL b2b_const: got mon=%h addr=%h expected c 40c", MonDReg, avm_address);
        end
    endtask

    task automatic test_priority();
        // ocimem_b wins over ocimem_a: the address load and read are dropped
        cfg_wait = 0;
        run_cmd(0, 32'h200, 0, 0, "prio_load");
        ref_mem[int'(m_addr)] = 32'h0BADF00D;
        jdo = {4'b0001, 2'b00, 32'h0BADF00D};
        ta = 1; tb = 1;
        @(negedge clk);
        ta = 0; tb = 0;
        repeat (4) @(negedge clk);
        m_mon = 32'h0BADF00D;
        n_vec++;
        if (wr_addr_q.size() !== 1 || rd_addr_q.size() !== 0 || avm_address !== 32'h204 || MonDReg !== m_mon) begin
            n_err++;
            $display("FAIL prio_b_over_a: got wr=%0d rd=%0d addr=%h mon=%h expected 1 0 204 %h",
                     wr_addr_q.size(), rd_addr_q.size(), avm_address, MonDReg, m_mon);
        end
        wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
        m_addr = 30'h81;
        // ocimem_a (load only) wins over no_action: no read at all
        jdo = {6'b0, 32'h300};
        ta = 1; tna = 1;
        @(negedge clk);
        ta = 0; tna = 0;
        repeat (4) @(negedge clk);
        m_addr = 30'hC0;
        n_vec++;
        if (rd_addr_q.size() !== 0 || avm_address !== 32'h300 || monitor_ready !== 1'b1) begin
            n_err++;
            $display("FAIL prio_a_over_na: got rd=%0d addr=%h rdy=%b expected 0 300 1", rd_addr_q.size(), avm_address, monitor_ready);
        end
        rd_addr_q.delete();
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] v;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            cfg_wait = $urandom_range(0, 3);
            cfg_dly  = $urandom_range(0, 2);
            cfg_zl   = bit'($urandom_range(0, 1));
            v = (kind == 0) ? 32'($urandom_range(0, 127)) : $urandom;
            run_cmd(kind, v, bit'($urandom_range(0, 1)), 1'b0, "random");
        end
        cfg_wait = 0; cfg_dly = 0; cfg_zl = 0;
    endtask

    task automatic test_timeout(input bit is_read);
        int n;
        cfg_stall = 1;
        jdo = {6'b0, 32'h55AA55AA};
        if (is_read) tna = 1; else tb = 1;
        @(negedge clk);
        tna = 0; tb = 0;
        n = 0;
        while (monitor_ready !== 1'b1 && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        cfg_stall = 0;
        m_mon = 32'hDEADDEAD;
        m_err = 1'b1;
        n_vec++;
        if (n !== TO) begin n_err++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
        n_vec++;
        if (MonDReg !== 32'hDEADDEAD || monitor_error !== 1'b1 || avm_address !== {m_addr, 2'b00} || {avm_read, avm_write} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_state: got mon=%h err=%b addr=%h rd=%b wr=%b expected deaddead 1 %h 0 0",
                     MonDReg, monitor_error, avm_address, avm_read, avm_write, {m_addr, 2'b00});
        end
        n_vec++;
        if (wr_addr_q.size() !== 0 || rd_addr_q.size() !== 0) begin
            n_err++; $display("FAIL timeout_bus: got wr=%0d rd=%0d expected 0 0", wr_addr_q.size(), rd_addr_q.size());
        end
        spurious_rdv = 1;
        repeat (2) @(negedge clk);
        spurious_rdv = 0;
        @(negedge clk);
        n_vec++;
        if (MonDReg !== 32'hDEADDEAD || monitor_ready !== 1'b1) begin
            n_err++; $display("FAIL late_rdv: got mon=%h rdy=%b expected deaddead 1", MonDReg, monitor_ready);
        end
        run_cmd(0, {m_addr, 2'b00}, 0, 1, "timeout_err_clear");
    endtask

    task automatic test_busy_error();
        int n;
        logic [31:0] exp, exp_baddr;
        cfg_wait = 0; cfg_zl = 0; cfg_dly = 4;
        exp = ref_rd(m_addr);
        exp_baddr = {m_addr, 2'b00};
        m_addr = m_addr + 30'd1;
        m_mon = exp;
        m_err = 1'b1;
        jdo = '0;
        tna = 1;
        @(negedge clk);
        tna = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (avm_read !== 1'b0 || monitor_ready !== 1'b0) begin
            n_err++; $display("FAIL busy_rd_data: got rd=%b rdy=%b expected 0 0", avm_read, monitor_ready);
        end
        tna = 1;
        @(negedge clk);
        tna = 0;
        n = 0;
        while (monitor_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (MonDReg !== exp || monitor_error !== 1'b1) begin
            n_err++; $display("FAIL busy_result: got mon=%h err=%b expected %h 1", MonDReg, monitor_error, exp);
        end
        n_vec++;
        if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== exp_baddr) begin
            n_err++; $display("FAIL busy_rd_log: got n=%0d expected 1 at %h", rd_addr_q.size(), exp_baddr);
        end
        rd_addr_q.delete();
        repeat (6) @(negedge clk);
        n_vec++;
        if (rd_addr_q.size() !== 0 || avm_read !== 1'b0 || avm_address !== {m_addr, 2'b00}) begin
            n_err++; $display("FAIL busy_ignored: got rd=%0d addr=%h expected 0 %h", rd_addr_q.size(), avm_address, {m_addr, 2'b00});
        end
        cfg_dly = 0;
        run_cmd(0, {m_addr, 2'b00}, 0, 1, "busy_err_clear");
    endtask

    task automatic test_reset_mid_write();
        cfg_stall = 1;
        jdo = {6'b0, 32'h77777777};
        tb = 1;
        @(negedge clk);
        tb = 0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (avm_write !== 1'b1) begin n_err++; $display("FAIL rst_pre_write: got %b expected 1", avm_write); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (avm_write !== 1'b0 || monitor_ready !== 1'b1 || avm_address !== 32'h0 || MonDReg !== 32'h0) begin
            n_err++;
            $display("FAIL rst_async: got wr=%b rdy=%b addr=%h mon=%h expected 0 1 0 0", avm_write, monitor_ready, avm_address, MonDReg);
        end
        cfg_stall = 0;
        @(negedge clk);
        reset_n = 1'b1;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (avm_write !== 1'b0 || avm_read !== 1'b0) begin
                n_vec++; n_err++;
                $display("FAIL rst_bus_quiet: got rd=%b wr=%b expected 0 0", avm_read, avm_write);
            end
        end
        n_vec++;
        if (wr_addr_q.size() !== 0) begin n_err++; $display("FAIL rst_no_write: got %0d expected 0", wr_addr_q.size()); end
    endtask

    task automatic test_addr_wrap();
        cfg_wait = 0;
        run_cmd(0, 32'hFFFFFFFC, 0, 0, "wrap_load");
        run_cmd(2, 32'hCAFEF00D, 0, 0, "wrap_write");
        n_vec++;
        if (avm_address !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h expected 0", avm_address); end
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        ta = 0; tna = 0; tb = 0;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_priority();
        test_random();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_busy_error();
        test_reset_mid_write();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
